rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer: circular queue of in-flight instructions.
- Allocates one entry per cycle at dispatch and hands its tag (Paddr) to the register alias table.
- Accepts out-of-order results from the common data bus and retires entries in program order, one per cycle.
- Drives the commit/flush interface of the register alias table and the operand-read ports of the issue queue.

Parameters:
- ROB_DEPTH, 8: number of entries; power of two, ≥4; tag width TW = $clog2(ROB_DEPTH).
- XLEN, 32: result data width.
- GPR_ADDR_WIDTH, 5: architectural register address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- alloc_req  in  1  dispatch requests an entry.
- alloc_dst_addr  in  GPR_ADDR_WIDTH  destination architectural register.
- alloc_dst_wen  in  1  instruction writes rd.
- alloc_ready  out  1  entry available (!full && !flush_pending).
- allocate_en  out  1  alloc_req && alloc_ready; to RAT.
- rob_alloc_tag_2rat  out  TW  tail index being allocated.
- rob_alloc_dst_addr_2rat / rob_alloc_dst_wen_2rat  out  GPR_ADDR_WIDTH / 1  pass-through of alloc_dst_addr / alloc_dst_wen.
- wb_en  in  1  CDB result valid.
- wb_tag  in  TW  entry being completed.
- wb_data  in  XLEN  result.
- wb_br_taken  in  1  branch mispredicted/taken-redirect.
- wb_exp  in  1  exception raised.
- rd1_tag / rd2_tag  in  TW  operand lookup tags from issue.
- rd1_ready / rd2_ready  out  1  entry done.
- rd1_data / rd2_data  out  XLEN  entry result.
- commit_dst_en  out  1  retiring entry writes rd.
- commit_valid  out  1  an entry retires this cycle.
- rob_commit_dst_addr_2rat  out  GPR_ADDR_WIDTH  retiring rd.
- rob_commit_Paddr  out  TW  head index.
- commit_data  out  XLEN  value for the register file.
- rob_commit_br_taken  out  1  retiring entry redirects.
- rob_commit_exp_en  out  1  retiring entry raises an exception.
- rob_empty / rob_full  out  1  status.

Behaviour:
- State:
  - Per entry: valid, done, dst_addr, dst_wen, data, br, exp.
  - Queue pointers: head, tail (TW bits); count (TW+1 bits).
- Reset (rst_n low at clk edge): all valid/done = 0; head = tail = count = 0. All outputs read 0, except alloc_ready = 1 and rob_empty = 1.
- Allocate:
  - When allocate_en: entry[tail] gets valid = 1, done = 0, br = 0, exp = 0, and the dst fields; tail wraps modulo ROB_DEPTH.
  - The tag is combinational (the current tail).
- Full:
  - Full means count == ROB_DEPTH, and alloc_ready = 0 while full.
  - Full is evaluated on the registered count. A commit in the same cycle does not free the slot until the next cycle.
- Writeback:
  - When wb_en and entry[wb_tag].valid: set done = 1 and latch data/br/exp.
  - A writeback to an invalid entry is ignored.
  - A second writeback to a done entry overwrites the latched fields.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, evaluated combinationally from registered state.
  - commit_dst_en = commit_valid && dst_wen && dst_addr != 0.
  - rob_commit_br_taken and rob_commit_exp_en = commit_valid && the entry's br / exp.
  - On commit the head entry's valid is cleared and head wraps.
  - A writeback to the head lands in cycle N; commit occurs in cycle N+1 at the earliest (one-cycle minimum latency).
- Flush:
  - Triggered by a commit with br or exp set: at that clock edge all entries are invalidated and head = tail = count = 0.
  - Any alloc or wb in the same cycle is discarded.
  - allocate_en is forced 0 in the flush cycle (flush_pending = the combinational flush condition).
- Count:
  - +1 on allocate only; −1 on commit only.
  - Unchanged when both occur (the empty-with-alloc case cannot commit).
  - Set to 0 on flush.
- Operand read: rdN_ready = valid && done and rdN_data = data for entry[rdN_tag], from registered state. An invalid entry returns ready = 0, data = 0.
- Empty: rob_empty = (count == 0).
- Reset mid-operation: all in-flight entries are discarded. No commit is asserted on the reset cycle or the cycle after.

Optional Feature:
- Macro ROB_WB_BYPASS_EN.
- Defined: rdN_ready/rdN_data additionally forward a same-cycle writeback when wb_en && wb_tag == rdN_tag && the entry is valid (ready = 1, data = wb_data).
- Undefined: operand reads see the result only from the cycle after the writeback.
- Commit timing is identical in both builds.

Test Plan:
- Reset, then 8 allocs (rd = 1..8, wen = 1) with no writeback → tags 0..7; after 8th, rob_full = 1 and alloc_ready = 0; a 9th alloc_req gives allocate_en = 0.
- Write back tags 2, 1, 0 in successive cycles → commits occur in order 0, 1, 2 only after tag 0 is done: commit_valid in the cycle after wb of tag 0, then the next two cycles with Paddr 1, 2.
- Alloc rd = 0, wen = 1, write it back → commit_valid = 1, commit_dst_en = 0.
- 4 entries, tag 1 written back with wb_br_taken = 1 and tags 0 and 2 done → commit 0, then commit 1 with rob_commit_br_taken = 1; the next cycle rob_empty = 1, head = tail = 0, tag 2 never commits; an alloc in the flush cycle is dropped.
- Full ROB with head done, alloc_req held → commit in cycle N, alloc_ready = 1 in N+1, new entry gets tag = old head tag; tail wraps 7→0.
- rd1_tag = 3, wb of tag 3 with data 0xDEADBEEF in the same cycle:
  - with ROB_WB_BYPASS_EN → rd1_ready = 1, rd1_data = 0xDEADBEEF that cycle.
  - without the macro → both appear one cycle later.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: circular queue that allocates in program order, completes out of order
// from the CDB and retires one entry per cycle. Optional macro ROB_WB_BYPASS_EN forwards
// a same-cycle writeback onto the issue-queue operand-read ports.
module rob #(
  parameter int ROB_DEPTH      = 8,
  parameter int XLEN           = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  localparam int TW            = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      alloc_req,
  input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
  input  logic                      alloc_dst_wen,
  output logic                      alloc_ready,
  output logic                      allocate_en,
  output logic [TW-1:0]             rob_alloc_tag_2rat,
  output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
  output logic                      rob_alloc_dst_wen_2rat,

  input  logic                      wb_en,
  input  logic [TW-1:0]             wb_tag,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      wb_br_taken,
  input  logic                      wb_exp,

  input  logic [TW-1:0]             rd1_tag,
  input  logic [TW-1:0]             rd2_tag,
  output logic                      rd1_ready,
  output logic                      rd2_ready,
  output logic [XLEN-1:0]           rd1_data,
  output logic [XLEN-1:0]           rd2_data,

  output logic                      commit_dst_en,
  output logic                      commit_valid,
  output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
  output logic [TW-1:0]             rob_commit_Paddr,
  output logic [XLEN-1:0]           commit_data,
  output logic                      rob_commit_br_taken,
  output logic                      rob_commit_exp_en,

  output logic                      rob_empty,
  output logic                      rob_full
);

  localparam logic [TW:0] FULL_COUNT = (TW+1)'(ROB_DEPTH);

  // Control state (reset)
  logic [TW-1:0]        head_q;
  logic [TW-1:0]        tail_q;
  logic [TW:0]          count_q;
  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;

  // Payload state (no reset)
  logic [XLEN-1:0]           data_q     [ROB_DEPTH];
  logic [GPR_ADDR_WIDTH-1:0] dst_addr_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]      dst_wen_q;
  logic [ROB_DEPTH-1:0]      br_q;
  logic [ROB_DEPTH-1:0]      exp_q;

  logic wb_hit;
  logic flush_pending;

  // ---------------------------------------------------------------------------
  // Allocation side
  // ---------------------------------------------------------------------------
  assign rob_full    = (count_q == FULL_COUNT);
  assign rob_empty   = (count_q == '0);
  assign alloc_ready = !rob_full && !flush_pending;
  assign allocate_en = alloc_req && alloc_ready;

  assign rob_alloc_tag_2rat      = tail_q;
  assign rob_alloc_dst_addr_2rat = alloc_dst_addr;
  assign rob_alloc_dst_wen_2rat  = alloc_dst_wen;

  assign wb_hit = wb_en && valid_q[wb_tag];

  // ---------------------------------------------------------------------------
  // Retire side: the head may leave only once its result is latched, and never
  // while reset is being applied.
  // ---------------------------------------------------------------------------
  assign commit_valid  = rst_n && valid_q[head_q] && done_q[head_q];
  assign flush_pending = commit_valid && (br_q[head_q] || exp_q[head_q]);

  assign commit_dst_en            = commit_valid && dst_wen_q[head_q] && (dst_addr_q[head_q] != '0);
  assign rob_commit_dst_addr_2rat = commit_valid ? dst_addr_q[head_q] : '0;
  assign commit_data              = commit_valid ? data_q[head_q] : '0;
  assign rob_commit_br_taken      = commit_valid && br_q[head_q];
  assign rob_commit_exp_en        = commit_valid && exp_q[head_q];
  assign rob_commit_Paddr         = head_q;

  // ---------------------------------------------------------------------------
  // Queue pointers and per-entry valid/done
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush_pending) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (wb_hit) begin
        done_q[wb_tag] <= 1'b1;
      end

      // The allocated slot is never the written-back one (it is invalid)
      // nor the head being retired (the queue would have to be full).
      if (allocate_en) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + TW'(1);
      end

      if (commit_valid) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + TW'(1);
      end

      unique case ({allocate_en, commit_valid})
        2'b10:   count_q <= count_q + (TW+1)'(1);
        2'b01:   count_q <= count_q - (TW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload
  // ---------------------------------------------------------------------------
  // NOTE: the payload array is deliberately not reset; every field is written
  // at allocate or writeback before valid/done let it reach an output.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_pending) begin
      if (allocate_en) begin
        dst_addr_q[tail_q] <= alloc_dst_addr;
        dst_wen_q[tail_q]  <= alloc_dst_wen;
        br_q[tail_q]       <= 1'b0;
        exp_q[tail_q]      <= 1'b0;
      end
      if (wb_hit) begin
        data_q[wb_tag] <= wb_data;
        br_q[wb_tag]   <= wb_br_taken;
        exp_q[wb_tag]  <= wb_exp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand-read ports for the issue queue
  // ---------------------------------------------------------------------------
  // NOTE: each combinational output gets a default at the top of its block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd1_ready = valid_q[rd1_tag] && done_q[rd1_tag];
    rd1_data  = rd1_ready ? data_q[rd1_tag] : '0;
`ifdef ROB_WB_BYPASS_EN
    if (wb_en && (wb_tag == rd1_tag) && valid_q[rd1_tag]) begin
      rd1_ready = 1'b1;
      rd1_data  = wb_data;
    end
`endif
  end

  always_comb begin
    rd2_ready = valid_q[rd2_tag] && done_q[rd2_tag];
    rd2_data  = rd2_ready ? data_q[rd2_tag] : '0;
`ifdef ROB_WB_BYPASS_EN
    if (wb_en && (wb_tag == rd2_tag) && valid_q[rd2_tag]) begin
      rd2_ready = 1'b1;
      rd2_data  = wb_data;
    end
`endif
  end

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for rob: fill/full, out-of-order completion, in-order
// retire, rd=0 commit, branch/exception flush, reset mid-operation, operand reads.
module tb_rob;

  localparam int TW = 3;
  localparam int XL = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          alloc_req;
  logic [AW-1:0] alloc_dst_addr;
  logic          alloc_dst_wen;
  logic          alloc_ready;
  logic          allocate_en;
  logic [TW-1:0] rob_alloc_tag_2rat;
  logic [AW-1:0] rob_alloc_dst_addr_2rat;
  logic          rob_alloc_dst_wen_2rat;
  logic          wb_en;
  logic [TW-1:0] wb_tag;
  logic [XL-1:0] wb_data;
  logic          wb_br_taken;
  logic          wb_exp;
  logic [TW-1:0] rd1_tag;
  logic [TW-1:0] rd2_tag;
  logic          rd1_ready;
  logic          rd2_ready;
  logic [XL-1:0] rd1_data;
  logic [XL-1:0] rd2_data;
  logic          commit_dst_en;
  logic          commit_valid;
  logic [AW-1:0] rob_commit_dst_addr_2rat;
  logic [TW-1:0] rob_commit_Paddr;
  logic [XL-1:0] commit_data;
  logic          rob_commit_br_taken;
  logic          rob_commit_exp_en;
  logic          rob_empty;
  logic          rob_full;

  int checks   = 0;
  int failures = 0;

  rob #(.ROB_DEPTH(8), .XLEN(XL), .GPR_ADDR_WIDTH(AW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .alloc_req               (alloc_req),
    .alloc_dst_addr          (alloc_dst_addr),
    .alloc_dst_wen           (alloc_dst_wen),
    .alloc_ready             (alloc_ready),
    .allocate_en             (allocate_en),
    .rob_alloc_tag_2rat      (rob_alloc_tag_2rat),
    .rob_alloc_dst_addr_2rat (rob_alloc_dst_addr_2rat),
    .rob_alloc_dst_wen_2rat  (rob_alloc_dst_wen_2rat),
    .wb_en                   (wb_en),
    .wb_tag                  (wb_tag),
    .wb_data                 (wb_data),
    .wb_br_taken             (wb_br_taken),
    .wb_exp                  (wb_exp),
    .rd1_tag                 (rd1_tag),
    .rd2_tag                 (rd2_tag),
    .rd1_ready               (rd1_ready),
    .rd2_ready               (rd2_ready),
    .rd1_data                (rd1_data),
    .rd2_data                (rd2_data),
    .commit_dst_en           (commit_dst_en),
    .commit_valid            (commit_valid),
    .rob_commit_dst_addr_2rat(rob_commit_dst_addr_2rat),
    .rob_commit_Paddr        (rob_commit_Paddr),
    .commit_data             (commit_data),
    .rob_commit_br_taken     (rob_commit_br_taken),
    .rob_commit_exp_en       (rob_commit_exp_en),
    .rob_empty               (rob_empty),
    .rob_full                (rob_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int drain_tag [5] = '{4, 5, 6, 7, 0};
  int drain_rd  [5] = '{5, 6, 7, 8, 0};

  initial begin
    rst_n = 1'b0; alloc_req = 1'b0; alloc_dst_addr = '0; alloc_dst_wen = 1'b0;
    wb_en = 1'b0; wb_tag = '0; wb_data = '0; wb_br_taken = 1'b0; wb_exp = 1'b0;
    rd1_tag = '0; rd2_tag = '0;
    tick();
    tick();

    // Reset state
    rst_n = 1'b1;
    settle();
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_empty", rob_empty, 1);
    check("rst_full", rob_full, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_allocate_en", allocate_en, 0);
    check("rst_alloc_tag", rob_alloc_tag_2rat, 0);
    check("rst_paddr", rob_commit_Paddr, 0);
    check("rst_commit_data", commit_data, 0);
    check("rst_rd1_ready", rd1_ready, 0);
    tick();

    // Fill all eight entries, rd = 1..8
    for (int i = 0; i < 8; i++) begin
      alloc_req = 1'b1; alloc_dst_addr = AW'(i + 1); alloc_dst_wen = 1'b1;
      settle();
      check("fill_allocate_en", allocate_en, 1);
      check("fill_tag", rob_alloc_tag_2rat, i);
      check("fill_rat_addr", rob_alloc_dst_addr_2rat, i + 1);
      tick();
    end
    settle();
    check("full_flag", rob_full, 1);
    check("full_alloc_ready", alloc_ready, 0);
    check("full_9th_alloc", allocate_en, 0);
    check("full_not_empty", rob_empty, 0);
    alloc_req = 1'b0;

    // Out-of-order completion 2,1,0: nothing retires until tag 0 is done
    wb_en = 1'b1; wb_tag = 3'd2; wb_data = 32'h102;
    settle(); check("ooo_wb2_no_commit", commit_valid, 0); tick();
    wb_tag = 3'd1; wb_data = 32'h101;
    settle(); check("ooo_wb1_no_commit", commit_valid, 0); tick();
    wb_tag = 3'd0; wb_data = 32'h100;
    settle(); check("ooo_wb0_latency", commit_valid, 0); tick();

    // Commit 0 while full; alloc held (rd=0) is refused this cycle
    wb_en = 1'b0;
    alloc_req = 1'b1; alloc_dst_addr = '0; alloc_dst_wen = 1'b1;
    settle();
    check("c0_valid", commit_valid, 1);
    check("c0_paddr", rob_commit_Paddr, 0);
    check("c0_data", commit_data, 32'h100);
    check("c0_dst_addr", rob_commit_dst_addr_2rat, 1);
    check("c0_dst_en", commit_dst_en, 1);
    check("c0_still_full", rob_full, 1);
    check("c0_alloc_ready", alloc_ready, 0);
    check("c0_allocate_en", allocate_en, 0);
    tick();
    settle();
    check("c1_valid", commit_valid, 1);
    check("c1_paddr", rob_commit_Paddr, 1);
    check("c1_data", commit_data, 32'h101);
    check("c1_not_full", rob_full, 0);
    check("c1_alloc_ready", alloc_ready, 1);
    check("c1_allocate_en", allocate_en, 1);
    check("c1_wrap_tag", rob_alloc_tag_2rat, 0);
    tick();
    alloc_req = 1'b0;
    settle();
    check("c2_valid", commit_valid, 1);
    check("c2_paddr", rob_commit_Paddr, 2);
    check("c2_data", commit_data, 32'h102);
    check("c2_tail", rob_alloc_tag_2rat, 1);
    tick();
    settle();
    check("c3_wait", commit_valid, 0);
    check("c3_head", rob_commit_Paddr, 3);

    // Operand read of tag 3 in the writeback cycle
    rd1_tag = 3'd3; rd2_tag = 3'd2;
    wb_en = 1'b1; wb_tag = 3'd3; wb_data = 32'hDEADBEEF;
    settle();
`ifdef ROB_WB_BYPASS_EN
    check("rd_same_ready", rd1_ready, 1);
    check("rd_same_data", rd1_data, 32'hDEADBEEF);
`else
    check("rd_same_ready", rd1_ready, 0);
    check("rd_same_data", rd1_data, 0);
`endif
    check("rd_invalid_ready", rd2_ready, 0);
    check("rd_invalid_data", rd2_data, 0);
    tick();
    wb_en = 1'b0; rd2_tag = 3'd4;
    settle();
    check("rd_next_ready", rd1_ready, 1);
    check("rd_next_data", rd1_data, 32'hDEADBEEF);
    check("rd_notdone_ready", rd2_ready, 0);
    check("c3_valid", commit_valid, 1);
    check("c3_paddr", rob_commit_Paddr, 3);
    check("c3_data", commit_data, 32'hDEADBEEF);
    check("c3_dst_addr", rob_commit_dst_addr_2rat, 4);
    tick();

    // Drain 4,5,6,7,0: each commits the cycle after its writeback
    for (int k = 0; k < 5; k++) begin
      wb_en = 1'b1; wb_tag = TW'(drain_tag[k]); wb_data = 32'h200 + 32'(k);
      settle();
      if (k == 0) begin
        check("drain_first_wait", commit_valid, 0);
      end else begin
        check("drain_valid", commit_valid, 1);
        check("drain_paddr", rob_commit_Paddr, drain_tag[k-1]);
        check("drain_data", commit_data, 32'h200 + 32'(k - 1));
        check("drain_dst_addr", rob_commit_dst_addr_2rat, drain_rd[k-1]);
        check("drain_dst_en", commit_dst_en, 1);
      end
      tick();
    end
    wb_en = 1'b0;
    settle();
    check("rd0_valid", commit_valid, 1);
    check("rd0_paddr", rob_commit_Paddr, 0);
    check("rd0_dst_en", commit_dst_en, 0);
    check("rd0_data", commit_data, 32'h204);
    tick();
    settle();
    check("drained_empty", rob_empty, 1);
    check("drained_no_commit", commit_valid, 0);
    check("drained_tail", rob_alloc_tag_2rat, 1);
    check("drained_head", rob_commit_Paddr, 1);

    // Reset with a retire-ready head: no commit on the reset cycle or after
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1; alloc_dst_addr = AW'(20 + i); alloc_dst_wen = 1'b1;
      tick();
    end
    alloc_req = 1'b0;
    wb_en = 1'b1; wb_tag = 3'd1; wb_data = 32'h55;
    tick();
    wb_en = 1'b0; rst_n = 1'b0;
    settle();
    check("midrst_no_commit", commit_valid, 0);
    tick();
    rst_n = 1'b1; rd1_tag = 3'd1;
    settle();
    check("postrst_no_commit", commit_valid, 0);
    check("postrst_empty", rob_empty, 1);
    check("postrst_tail", rob_alloc_tag_2rat, 0);
    check("postrst_head", rob_commit_Paddr, 0);
    check("postrst_rd_ready", rd1_ready, 0);

    // Branch flush: tags 0..3, tag 1 redirects, tag 2 done but never retires
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1; alloc_dst_addr = AW'(10 + i); alloc_dst_wen = 1'b1;
      tick();
    end
    alloc_req = 1'b0; rd1_tag = 3'd2;
    wb_en = 1'b1; wb_tag = 3'd2; wb_data = 32'h22;
    tick();
    wb_data = 32'h2F;
    tick();
    wb_tag = 3'd1; wb_data = 32'h11; wb_br_taken = 1'b1;
    settle();
    check("rewb_ready", rd1_ready, 1);
    check("rewb_data", rd1_data, 32'h2F);
    tick();
    wb_tag = 3'd0; wb_data = 32'h33; wb_br_taken = 1'b0;
    tick();
    wb_en = 1'b0;
    settle();
    check("fl_c0_valid", commit_valid, 1);
    check("fl_c0_paddr", rob_commit_Paddr, 0);
    check("fl_c0_br", rob_commit_br_taken, 0);
    check("fl_c0_data", commit_data, 32'h33);
    check("fl_c0_dst_addr", rob_commit_dst_addr_2rat, 10);
    tick();
    alloc_req = 1'b1; alloc_dst_addr = 5'd15;
    wb_en = 1'b1; wb_tag = 3'd3; wb_data = 32'h44;
    settle();
    check("fl_c1_valid", commit_valid, 1);
    check("fl_c1_paddr", rob_commit_Paddr, 1);
    check("fl_c1_br", rob_commit_br_taken, 1);
    check("fl_c1_exp", rob_commit_exp_en, 0);
    check("fl_c1_data", commit_data, 32'h11);
    check("fl_alloc_ready", alloc_ready, 0);
    check("fl_alloc_dropped", allocate_en, 0);
    tick();
    alloc_req = 1'b0; wb_en = 1'b0; rd1_tag = 3'd2; rd2_tag = 3'd3;
    settle();
    check("fl_empty", rob_empty, 1);
    check("fl_no_commit", commit_valid, 0);
    check("fl_tail", rob_alloc_tag_2rat, 0);
    check("fl_head", rob_commit_Paddr, 0);
    check("fl_tag2_gone", rd1_ready, 0);
    check("fl_tag3_gone", rd2_ready, 0);
    check("fl_not_full", rob_full, 0);

    // Writeback to an invalid entry is ignored
    wb_en = 1'b1; wb_tag = 3'd5; wb_data = 32'h77;
    tick();
    wb_en = 1'b0; rd1_tag = 3'd5;
    settle();
    check("inv_wb_ready", rd1_ready, 0);
    check("inv_wb_data", rd1_data, 0);

    // Exception flush
    alloc_req = 1'b1; alloc_dst_addr = 5'd3; alloc_dst_wen = 1'b1;
    settle();
    check("ex_allocate_en", allocate_en, 1);
    check("ex_tag", rob_alloc_tag_2rat, 0);
    tick();
    alloc_req = 1'b0;
    wb_en = 1'b1; wb_tag = 3'd0; wb_data = 32'h99; wb_exp = 1'b1;
    tick();
    wb_en = 1'b0; wb_exp = 1'b0;
    settle();
    check("ex_valid", commit_valid, 1);
    check("ex_exp_en", rob_commit_exp_en, 1);
    check("ex_br", rob_commit_br_taken, 0);
    check("ex_dst_en", commit_dst_en, 1);
    check("ex_dst_addr", rob_commit_dst_addr_2rat, 3);
    check("ex_data", commit_data, 32'h99);
    check("ex_alloc_ready", alloc_ready, 0);
    tick();
    settle();
    check("ex_empty", rob_empty, 1);
    check("ex_no_commit", commit_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
